cgra_ctx_scheduler: RTL and testbench
=====================================

# cgra_ctx_scheduler

Context scheduler for the 3x3 PE array, its three AGU controls and the three-port memory. It sequences the array through a loop of configuration contexts. It drives the shared context-RAM read address and enable, and generates the `start` strobe consumed by every PE and AGU control. Pipeline stalls hold the sequence in place, and a drain phase lets in-flight results reach memory before `done` is reported.

## Interface
- `CTX_AW`, 5: context address width; up to 2^CTX_AW contexts per loop body.
- `ITER_W`, 16: iteration counter width.
- `DRAIN_CYCLES`, 3: number of cycles after the last issue before `done` (at least 1).

Ports:
- `CLK`  in  1  single clock; every register is rising-edge.
- `RST`  in  1  asynchronous, active-high reset.
- `go`  in  1  launch request; sampled only in IDLE.
- `cfg_last_ctx`  in  CTX_AW  index of the last context in the loop body; captured on an accepted `go`.
- `cfg_iters`  in  ITER_W  loop iteration count; captured on an accepted `go`.
- `stall`  in  1  freezes issue and drain counting while high.
- `abort`  in  1  cancels a running schedule; ignored in IDLE.
- `ctx_addr`  out  CTX_AW  context-RAM read address, registered.
- `ctx_rd_en`  out  1  context-RAM read enable; `(state==ISSUE) & ~stall`.
- `start`  out  1  registered copy of `ctx_rd_en`; marks context data valid at the PEs and AGU controls.
- `iter_idx`  out  ITER_W  iteration number of the context currently being issued.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  one-cycle abort acknowledge.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `go` with `cfg_iters != 0` captures the config, clears `ctx_addr` and `iter_idx`, and moves to ISSUE.
  - `go` with `cfg_iters == 0` moves to DONE with no issue.
- ISSUE:
  - Every cycle with `ctx_rd_en=1` issues `ctx_addr`.
  - When `ctx_addr == last_ctx`, the address wraps to 0 and `iter_idx` increments.
  - When the issued address is `last_ctx` and `iter_idx == iters-1`, the state moves to DRAIN and `ctx_addr` and `iter_idx` hold.
- `stall` in ISSUE:
  - `ctx_rd_en` goes low and the address and counters hold.
  - The context RAM keeps its output, so the PEs see held data with `start` low.
- DRAIN:
  - A down-counter loads `DRAIN_CYCLES` on entry and decrements on each non-stalled cycle.
  - When the counter reaches 0 the state moves to DONE.
- DONE: `done=1` for one cycle, then IDLE. `go` is ignored in DONE.
- `abort` in ISSUE, DRAIN or DONE:
  - Next state is IDLE, with `aborted=1` for one cycle.
  - No `done` is generated.
  - `ctx_addr`, `iter_idx` and `start` clear.
- `abort` has priority over `stall`.
- `go` and `abort` together in IDLE: `go` is accepted.
- Config inputs are ignored outside IDLE; captured values cannot change mid-run.
- Arithmetic:
  - Counters are unsigned and compare before incrementing, so no overflow is possible.
  - Maximum run length is `2^CTX_AW * (2^ITER_W - 1)` issues.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset takes effect immediately on `RST`, including mid-run; no `done` or `aborted` is produced.
- Cycle numbering below counts `go` sampled high at cycle 0, with no stalls, N = `last_ctx+1` and I = `iters`.
- Issue:
  - `ctx_rd_en` is high in cycles 1..N*I.
  - `ctx_addr` in cycle k is `(k-1) mod N`.
- Start: `start` is high in cycles 2..N*I+1, one cycle after each read (1-cycle RAM latency).
- Drain: `busy` is high in cycles 1..N*I+DRAIN_CYCLES.
- Completion: `done` is high in cycle N*I+DRAIN_CYCLES+1, then the block is in IDLE.
- Stalls: each stalled cycle in ISSUE or DRAIN delays `done` by exactly one cycle.
- Abort: `aborted` is high in the cycle after `abort` is sampled; `busy` is low in that cycle.
- Re-launch: a new `go` is accepted in the first IDLE cycle after `done` or `aborted`.

## Test plan
- **Basic loop.** `last_ctx=2`, `iters=2`, `DRAIN_CYCLES=3`, `go` at cycle 0 -> `ctx_addr` 0,1,2,0,1,2 in cycles 1-6, `iter_idx` 0,0,0,1,1,1, `start` in cycles 2-7, `done` at cycle 10 only.
- **Stall.** Same setup with `stall` high in cycles 3-4 -> `ctx_rd_en` low in cycles 3-4, `ctx_addr` holds 2, `start` low in cycles 4-5, `done` at cycle 12.
- **Zero iterations.** `cfg_iters=0`, `go` -> `done` at cycle 1; `ctx_rd_en`, `start` and `busy` are never high.
- **Single context.** `last_ctx=0`, `iters=3` -> `ctx_addr` is 0 throughout, `ctx_rd_en` high in cycles 1-3, `iter_idx` 0,1,2, `done` at cycle 7.
- **Abort.** Basic setup with `abort` at cycle 4 -> in cycle 5 `aborted=1`, `busy=0`, `ctx_addr=0`, and `done` never fires. A `go` at cycle 6 restarts the loop from `ctx_addr=0` in cycle 7.
- **Reset mid-run.** `RST` pulsed mid-cycle at cycle 5 -> all outputs go to 0 immediately, no `done`, and a `go` after reset release behaves as in the basic-loop scenario.

Source files
------------

// File: rtl/cgra_ctx_scheduler.sv
// Context scheduler for the 3x3 PE array: walks the context RAM through the
// loop body, strobes start one cycle after each read, then drains and reports done.
module cgra_ctx_scheduler #(
  parameter int CTX_AW       = 5,
  parameter int ITER_W       = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              go,
  input  logic [CTX_AW-1:0] cfg_last_ctx,
  input  logic [ITER_W-1:0] cfg_iters,
  input  logic              stall,
  input  logic              abort,
  output logic [CTX_AW-1:0] ctx_addr,
  output logic              ctx_rd_en,
  output logic              start,
  output logic [ITER_W-1:0] iter_idx,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CTX_AW-1:0] addr_q, addr_d;
  logic [CTX_AW-1:0] last_q, last_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              start_q, start_d;
  logic              aborted_q, aborted_d;
  logic              rd_en;

  assign rd_en = (state_q == ISSUE) && !stall;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    iter_d    = iter_q;
    iters_d   = iters_q;
    drain_d   = drain_q;
    start_d   = rd_en;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          last_d  = cfg_last_ctx;
          iters_d = cfg_iters;
          addr_d  = '0;
          iter_d  = '0;
          state_d = (cfg_iters != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (addr_q == last_q) begin
            // Final issue of the final iteration: hold address and index for drain.
            if (iter_q == iters_q - ITER_W'(1)) begin
              state_d = DRAIN;
              drain_d = DW'(DRAIN_CYCLES);
            end else begin
              addr_d = '0;
              iter_d = iter_q + ITER_W'(1);
            end
          end else begin
            addr_d = addr_q + CTX_AW'(1);
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          drain_d = drain_q - DW'(1);
          if (drain_q <= DW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including stall, once a run is under way.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      addr_d    = '0;
      iter_d    = '0;
      drain_d   = '0;
      start_d   = 1'b0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      iter_q    <= '0;
      iters_q   <= '0;
      drain_q   <= '0;
      start_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      iter_q    <= iter_d;
      iters_q   <= iters_d;
      drain_q   <= drain_d;
      start_q   <= start_d;
      aborted_q <= aborted_d;
    end
  end

  assign ctx_addr  = addr_q;
  assign ctx_rd_en = rd_en;
  assign start     = start_q;
  assign iter_idx  = iter_q;
  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  // An abort arriving in DONE suppresses the completion pulse.
  assign done      = (state_q == DONE) && !abort;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_cgra_ctx_scheduler.sv
// Directed testbench for cgra_ctx_scheduler: basic loop, stall, zero iterations,
// single context, abort/relaunch and asynchronous reset mid-run.
module tb_cgra_ctx_scheduler;

  localparam int CTX_AW = 5;
  localparam int ITER_W = 16;
  localparam int DRAIN_CYCLES = 3;

  logic              CLK;
  logic              RST;
  logic              go;
  logic [CTX_AW-1:0] cfg_last_ctx;
  logic [ITER_W-1:0] cfg_iters;
  logic              stall;
  logic              abort;
  logic [CTX_AW-1:0] ctx_addr;
  logic              ctx_rd_en;
  logic              start;
  logic [ITER_W-1:0] iter_idx;
  logic              busy;
  logic              done;
  logic              aborted;

  int compareCount;
  int mismatchCount;

  cgra_ctx_scheduler #(
    .CTX_AW(CTX_AW),
    .ITER_W(ITER_W),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .go(go),
    .cfg_last_ctx(cfg_last_ctx),
    .cfg_iters(cfg_iters),
    .stall(stall),
    .abort(abort),
    .ctx_addr(ctx_addr),
    .ctx_rd_en(ctx_rd_en),
    .start(start),
    .iter_idx(iter_idx),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " ctx_addr"}, 32'(ctx_addr), 32'd0);
    checkOutput({tag, " ctx_rd_en"}, 32'(ctx_rd_en), 32'd0);
    checkOutput({tag, " start"}, 32'(start), 32'd0);
    checkOutput({tag, " iter_idx"}, 32'(iter_idx), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " aborted"}, 32'(aborted), 32'd0);
  endtask

  // Called just after a falling edge (cycle 0); drives go and follows the run
  // through the hand-given done cycle, with stall high in cycles stallA..stallB.
  task automatic applyStimulus(input string tag, input int last, input int iters,
                               input int stallA, input int stallB, input int doneCyc);
    int  n;
    int  total;
    int  issued;
    int  expAddr;
    int  expIter;
    bit  prevRd;
    bit  stl;
    bit  rdE;
    n      = last + 1;
    total  = n * iters;
    issued = 0;
    prevRd = 1'b0;
    go           = 1'b1;
    cfg_last_ctx = CTX_AW'(last);
    cfg_iters    = ITER_W'(iters);
    stall        = 1'b0;
    for (int c = 1; c <= doneCyc + 1; c++) begin
      @(negedge CLK);
      go    = 1'b0;
      stl   = (c >= stallA) && (c <= stallB);
      stall = stl;
      #1;
      rdE     = (issued < total) && !stl;
      expAddr = (issued < total) ? (issued % n) : (n - 1);
      expIter = (issued < total) ? (issued / n) : (iters - 1);
      checkOutput({tag, " ctx_rd_en"}, 32'(ctx_rd_en), 32'(rdE));
      checkOutput({tag, " ctx_addr"}, 32'(ctx_addr), 32'(expAddr));
      checkOutput({tag, " iter_idx"}, 32'(iter_idx), 32'(expIter));
      checkOutput({tag, " start"}, 32'(start), 32'(prevRd));
      checkOutput({tag, " busy"}, 32'(busy), 32'(c < doneCyc));
      checkOutput({tag, " done"}, 32'(done), 32'(c == doneCyc));
      checkOutput({tag, " aborted"}, 32'(aborted), 32'd0);
      if (rdE) issued++;
      prevRd = rdE;
    end
    stall = 1'b0;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    RST           = 1'b1;
    go            = 1'b0;
    cfg_last_ctx  = '0;
    cfg_iters     = '0;
    stall         = 1'b0;
    abort         = 1'b0;

    @(negedge CLK);
    #1;
    checkIdleOutputs("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Basic loop: last_ctx=2, iters=2 -> done at cycle 10.
    applyStimulus("basic", 2, 2, 0, -1, 10);

    // Stall in cycles 3-4 delays done to cycle 12.
    applyStimulus("stall", 2, 2, 3, 4, 12);

    // Single context, three iterations -> done at cycle 7.
    applyStimulus("single", 0, 3, 0, -1, 7);

    // Zero iterations: straight to DONE in cycle 1.
    go        = 1'b1;
    cfg_iters = '0;
    cfg_last_ctx = CTX_AW'(4);
    @(negedge CLK);
    go = 1'b0;
    #1;
    checkOutput("zero done", 32'(done), 32'd1);
    checkOutput("zero ctx_rd_en", 32'(ctx_rd_en), 32'd0);
    checkOutput("zero busy", 32'(busy), 32'd0);
    checkOutput("zero start", 32'(start), 32'd0);
    @(negedge CLK);
    #1;
    checkIdleOutputs("zero after");

    // Abort at cycle 4 of the basic loop, relaunch at cycle 6.
    @(negedge CLK);
    go           = 1'b1;
    cfg_last_ctx = CTX_AW'(2);
    cfg_iters    = ITER_W'(2);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      go = 1'b0;
      if (c == 4) abort = 1'b1;
      #1;
      checkOutput("abort pre ctx_addr", 32'(ctx_addr), 32'((c - 1) % 3));
      checkOutput("abort pre done", 32'(done), 32'd0);
    end
    @(negedge CLK);
    abort = 1'b0;
    #1;
    checkOutput("abort aborted", 32'(aborted), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort ctx_addr", 32'(ctx_addr), 32'd0);
    checkOutput("abort iter_idx", 32'(iter_idx), 32'd0);
    checkOutput("abort start", 32'(start), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    @(negedge CLK);
    #1;
    checkOutput("abort pulse end", 32'(aborted), 32'd0);
    checkOutput("abort idle done", 32'(done), 32'd0);
    applyStimulus("relaunch", 2, 2, 0, -1, 10);

    // Asynchronous reset in the middle of cycle 5 of a basic run.
    go           = 1'b1;
    cfg_last_ctx = CTX_AW'(2);
    cfg_iters    = ITER_W'(2);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      go = 1'b0;
    end
    #1;
    checkOutput("prereset busy", 32'(busy), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    checkIdleOutputs("midreset");
    @(negedge CLK);
    #1;
    checkIdleOutputs("inreset");
    RST = 1'b0;
    @(negedge CLK);
    #1;
    checkIdleOutputs("postreset");
    applyStimulus("afterreset", 2, 2, 0, -1, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
